alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer for MUL and DIV instructions, which the single-cycle ALU cannot execute. Sits beside the ALU in the EX stage. On a start pulse it latches the operands, runs an iterative shift-add multiply or restoring divide, and stalls the pipeline until the result is ready. Supports flush (branch/exception squash) and divide-by-zero.

Parameters:
WIDTH, 32, operand width in bits (>=4)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  EX-stage request; sampled only in IDLE
op  input  1  0 = unsigned MUL, 1 = unsigned DIV; sampled with start
flush  input  1  squash in-flight operation
a  input  WIDTH  multiplicand / dividend; sampled with start
b  input  WIDTH  multiplier / divisor; sampled with start
stall  output  1  holds IF/ID/EX while an operation is pending
busy  output  1  high in MUL or DIV state
done  output  1  one-cycle pulse, result valid
result_lo  output  WIDTH  MUL: product[WIDTH-1:0]; DIV: quotient
result_hi  output  WIDTH  MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder
div_by_zero  output  1  pulses with done when DIV had b==0

Behaviour:
- Reset: state=IDLE. stall, busy, done, div_by_zero, result_lo and result_hi are all 0. Internal counter and operand registers are cleared. Reset takes priority over everything, including mid-operation.
- States: IDLE, MUL, DIV, DONE.
- IDLE + start, op=0 -> MUL. Latch a and b, counter=WIDTH.
- IDLE + start, op=1, b!=0 -> DIV. Latch a and b, counter=WIDTH.
- IDLE + start, op=1, b==0 -> DONE. Set quotient to all ones, remainder to a, div_by_zero flag.
- MUL: shift-add, one bit per cycle. If the multiplier LSB is 1, acc_hi += multiplicand (carry kept in a WIDTH+1 adder). Then {carry, acc_hi, acc_lo} shifts right by 1. Counter decrements. When counter reaches 1 -> DONE.
- DIV: restoring division, one bit per cycle. {rem, dividend} shifts left by 1; trial = rem - divisor (WIDTH+1 bits). If trial is non-negative, rem=trial and the quotient LSB is 1; otherwise the quotient LSB is 0. Counter decrements. When counter reaches 1 -> DONE.
- DONE: done=1 for exactly this cycle. result_lo and result_hi update on entry to DONE and are valid while done=1. div_by_zero equals the latched flag. Unconditional -> IDLE.
- Latency: start at cycle 0. done at cycle WIDTH+1 for MUL and for DIV with b!=0. done at cycle 1 for divide-by-zero. MUL with b==0 still takes the full WIDTH cycles.
- stall = (IDLE & start & ~flush) | MUL | DIV. stall is combinational, so it is high in the start cycle and low in the DONE cycle, letting the instruction advance with the result.
- busy = MUL | DIV, registered from state.
- result_lo and result_hi hold their last value until the next DONE. They are not changed by flush.
- flush: from MUL, DIV or DONE -> IDLE next cycle. No done and no div_by_zero pulse are produced, stall deasserts the next cycle, and partial results are discarded. flush has priority over start in IDLE: no operation begins and stall stays 0.
- start outside IDLE is ignored. Operands are latched, so a and b may change after the start cycle without effect.
- Both MUL and DIV are unsigned. Widths are exact, with no truncation of the 2*WIDTH product.

Test Plan:
- WIDTH=32, MUL a=0xFFFFFFFF b=0xFFFFFFFF -> done at cycle 33, result_hi=0xFFFFFFFE, result_lo=0x00000001; stall high cycles 0-32, low at 33.
- DIV a=100 b=7 -> done at cycle 33, result_lo=14, result_hi=2, div_by_zero=0. Also DIV a=5 b=9 -> quotient 0, remainder 5.
- DIV a=0x1234 b=0 -> done at cycle 1, result_lo=0xFFFFFFFF, result_hi=0x1234, div_by_zero=1; stall high only in cycle 0.
- MUL 7*9 with flush at cycle 10 -> no done, stall=0 at cycle 11, result registers unchanged. Then MUL 3*5 -> result_lo=15, result_hi=0.
- Start pulse and new a/b values during busy -> ignored; the original result is unchanged. start with flush in IDLE -> stall=0, state stays IDLE.
- reset asserted mid-DIV at cycle 20 -> next cycle all outputs 0, state IDLE. A following MUL 2*3 -> result_lo=6 at cycle 33.

Source files
------------

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the EX stage and the multi-cycle MUL/DIV
// sequencer. The master side (pipeline) issues requests, the slave side
// (sequencer) returns stall/status and the 2*WIDTH-bit result.
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic             flush;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op, flush, a, b,
    input  stall, busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, flush, a, b,
    output stall, busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply / divide sequencer for the EX stage.
// MUL is a radix-2 shift-add over WIDTH cycles, DIV is a restoring divider
// over WIDTH cycles. A zero divisor short-circuits straight to DONE. The
// pipeline is held with a combinational stall while an operation is pending.
//
// Register reuse:
//   MUL: opnd = multiplicand, acc_hi = partial product high half,
//        acc_lo = multiplier shifting out / product low half shifting in
//   DIV: opnd = divisor, acc_hi = partial remainder,
//        acc_lo = dividend shifting out / quotient shifting in
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  alu_muldiv_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] result_lo_q, result_lo_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;

  logic             last_iter;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx;
  logic [WIDTH-1:0] mul_lo_nx;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] div_rem_nx;
  logic [WIDTH-1:0] div_quo_nx;

  assign last_iter = (cnt_q == CNT_W'(1));

  // One shift-add multiply step and one restoring divide step, both from the current registers
  always_comb begin
    // Carry out of the add is kept as the bit shifted into acc_hi's MSB.
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

    // The shifted remainder is below 2*divisor, so bit WIDTH of the
    // (WIDTH+1)-bit difference is a reliable sign bit.
    div_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_trial = div_sh - {1'b0, opnd_q};
    if (!div_trial[WIDTH]) begin
      div_rem_nx = div_trial[WIDTH-1:0];
      div_quo_nx = {acc_lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_nx = div_sh[WIDTH-1:0];
      div_quo_nx = {acc_lo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state, datapath and registered-output selection for the sequencer FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opnd_d      = opnd_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    result_lo_d = result_lo_q;
    result_hi_d = result_hi_q;
    done_d      = 1'b0;
    dbz_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          if (!bus.op) begin
            state_d  = S_MUL;
            cnt_d    = CNT_W'(WIDTH);
            opnd_d   = bus.a;
            acc_hi_d = '0;
            acc_lo_d = bus.b;
          end else if (bus.b != '0) begin
            state_d  = S_DIV;
            cnt_d    = CNT_W'(WIDTH);
            opnd_d   = bus.b;
            acc_hi_d = '0;
            acc_lo_d = bus.a;
          end else begin
            // Divide by zero: all-ones quotient, dividend as remainder.
            state_d     = S_DONE;
            result_lo_d = '1;
            result_hi_d = bus.a;
            done_d      = 1'b1;
            dbz_d       = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_hi_d = mul_hi_nx;
          acc_lo_d = mul_lo_nx;
          cnt_d    = cnt_q - CNT_W'(1);
          if (last_iter) begin
            state_d     = S_DONE;
            result_lo_d = mul_lo_nx;
            result_hi_d = mul_hi_nx;
            done_d      = 1'b1;
          end
        end
      end
      S_DIV: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_hi_d = div_rem_nx;
          acc_lo_d = div_quo_nx;
          cnt_d    = cnt_q - CNT_W'(1);
          if (last_iter) begin
            state_d     = S_DONE;
            result_lo_d = div_quo_nx;
            result_hi_d = div_rem_nx;
            done_d      = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
  end

  // State and datapath registers; reset clears everything, including mid-operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      opnd_q      <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opnd_q      <= opnd_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      result_lo_q <= result_lo_d;
      result_hi_q <= result_hi_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
    end
  end

  // Stall covers the request cycle itself so the instruction waits from the start;
  // a flush arriving in DONE squashes the completion pulse.
  assign bus.stall       = ((state_q == S_IDLE) && bus.start && !bus.flush) ||
                           (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.busy        = busy_q;
  assign bus.done        = done_q && !bus.flush;
  assign bus.div_by_zero = dbz_q && !bus.flush;
  assign bus.result_lo   = result_lo_q;
  assign bus.result_hi   = result_hi_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_alu_muldiv_seq;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [WIDTH-1:0] last_lo = '0;
  logic [WIDTH-1:0] last_hi = '0;

  alu_muldiv_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_muldiv_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: exact unsigned arithmetic and the documented latency.
  function automatic void ref_op(input logic op_i, input logic [WIDTH-1:0] a_i, b_i,
                                 output logic [WIDTH-1:0] lo, hi, output logic dbz,
                                 output int lat);
    logic [2*WIDTH-1:0] p;
    p = '0;
    if (!op_i) begin
      p = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
      lo = p[WIDTH-1:0]; hi = p[2*WIDTH-1:WIDTH]; dbz = 1'b0; lat = WIDTH + 1;
    end else if (b_i == '0) begin
      lo = '1; hi = a_i; dbz = 1'b1; lat = 1;
    end else begin
      lo = a_i / b_i; hi = a_i % b_i; dbz = 1'b0; lat = WIDTH + 1;
    end
  endfunction

  // Drives one operation starting at cycle 0 and observes lat+tail cycles.
  // proto_err counts cycles where stall/busy/done/div_by_zero differ from
  // the expected timeline.
  task automatic run_op(input logic op_i, input logic [WIDTH-1:0] a_i, b_i,
                        input int flush_cyc, input bit noise, input int tail,
                        output int done_cyc, output logic [WIDTH-1:0] lo, hi,
                        output logic dbz, output int proto_err);
    logic [WIDTH-1:0] elo, ehi;
    logic edbz;
    int   lat;
    bit   killed, exp_stall, exp_busy, exp_done;
    ref_op(op_i, a_i, b_i, elo, ehi, edbz, lat);
    killed = (flush_cyc >= 0) && (flush_cyc < lat);
    done_cyc = -1; proto_err = 0; lo = '0; hi = '0; dbz = 1'b0;
    for (int k = 0; k < lat + tail; k++) begin
      @(negedge clk);
      bus.start = (k == 0) || (noise && !killed && k < lat && $urandom_range(0, 1) == 1);
      bus.op    = (k == 0) ? op_i : 1'($urandom_range(0, 1));
      bus.a     = (k == 0) ? a_i : $urandom;
      bus.b     = (k == 0) ? b_i : $urandom;
      bus.flush = (k == flush_cyc);
      #1;
      if (flush_cyc == 0) begin
        exp_stall = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
      end else begin
        exp_stall = (k < lat) && (!killed || k <= flush_cyc);
        exp_busy  = (k >= 1) && (k < lat) && (!killed || k <= flush_cyc);
        exp_done  = !killed && (k == lat);
      end
      if (bus.stall !== exp_stall || bus.busy !== exp_busy || bus.done !== exp_done ||
          (!exp_done && bus.div_by_zero !== 1'b0))
        proto_err++;
      if (bus.done === 1'b1 && done_cyc < 0) begin
        done_cyc = k; lo = bus.result_lo; hi = bus.result_hi; dbz = bus.div_by_zero;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.op = 1'b0; bus.flush = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.stall, bus.busy, bus.done, bus.div_by_zero, bus.result_lo, bus.result_hi} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b busy=%b done=%b dbz=%b lo=%h hi=%h, want all 0",
               bus.stall, bus.busy, bus.done, bus.div_by_zero, bus.result_lo, bus.result_hi);
    end
    @(negedge clk);
    reset = 1'b0;
    last_lo = '0; last_hi = '0;
  endtask

  task automatic test_mul();
    int dc, pe; logic [WIDTH-1:0] lo, hi; logic dbz;
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 2, dc, lo, hi, dbz, pe);
    checks++; if (dc !== 33) begin errors++; $display("FAIL mul_ff_latency: got %0d want 33", dc); end
    checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL mul_ff_result: got %h_%h want fffffffe_00000001", hi, lo); end
    checks++; if (pe !== 0) begin errors++; $display("FAIL mul_ff_timeline: %0d bad cycles want 0", pe); end
    run_op(1'b0, 32'd123, 32'd0, -1, 1'b0, 2, dc, lo, hi, dbz, pe);
    checks++; if (dc !== 33 || {hi, lo} !== 64'd0 || pe !== 0) begin errors++; $display("FAIL mul_by_zero: got dc=%0d %h_%h pe=%0d want dc=33 0 pe=0", dc, hi, lo, pe); end
    last_lo = lo; last_hi = hi;
  endtask

  task automatic test_div();
    int dc, pe; logic [WIDTH-1:0] lo, hi; logic dbz;
    run_op(1'b1, 32'd100, 32'd7, -1, 1'b0, 2, dc, lo, hi, dbz, pe);
    checks++; if (dc !== 33) begin errors++; $display("FAIL div_100_7_latency: got %0d want 33", dc); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2 || dbz !== 1'b0) begin errors++; $display("FAIL div_100_7_result: got q=%0d r=%0d dbz=%b want 14 2 0", lo, hi, dbz); end
    checks++; if (pe !== 0) begin errors++; $display("FAIL div_100_7_timeline: %0d bad cycles want 0", pe); end
    run_op(1'b1, 32'd5, 32'd9, -1, 1'b0, 2, dc, lo, hi, dbz, pe);
    checks++; if (dc !== 33 || lo !== 32'd0 || hi !== 32'd5 || pe !== 0) begin errors++; $display("FAIL div_5_9: got dc=%0d q=%0d r=%0d pe=%0d want 33 0 5 0", dc, lo, hi, pe); end
    last_lo = lo; last_hi = hi;
  endtask

  task automatic test_div_by_zero();
    int dc, pe; logic [WIDTH-1:0] lo, hi; logic dbz;
    run_op(1'b1, 32'h1234, 32'd0, -1, 1'b0, 3, dc, lo, hi, dbz, pe);
    checks++; if (dc !== 1) begin errors++; $display("FAIL dbz_latency: got %0d want 1", dc); end
    checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h1234 || dbz !== 1'b1) begin errors++; $display("FAIL dbz_result: got q=%h r=%h dbz=%b want ffffffff 00001234 1", lo, hi, dbz); end
    checks++; if (pe !== 0) begin errors++; $display("FAIL dbz_timeline: %0d bad cycles want 0", pe); end
    last_lo = 32'hFFFF_FFFF; last_hi = 32'h1234;
  endtask

  task automatic test_flush();
    int dc, pe; logic [WIDTH-1:0] lo, hi; logic dbz;
    run_op(1'b0, 32'd7, 32'd9, 10, 1'b0, 3, dc, lo, hi, dbz, pe);
    checks++; if (dc !== -1) begin errors++; $display("FAIL flush_no_done: done seen at cycle %0d want none", dc); end
    checks++; if (pe !== 0) begin errors++; $display("FAIL flush_timeline: %0d bad cycles want 0", pe); end
    checks++; if (bus.result_lo !== last_lo || bus.result_hi !== last_hi) begin errors++; $display("FAIL flush_results_held: got %h_%h want %h_%h", bus.result_hi, bus.result_lo, last_hi, last_lo); end
    run_op(1'b0, 32'd3, 32'd5, -1, 1'b0, 2, dc, lo, hi, dbz, pe);
    checks++; if (dc !== 33 || lo !== 32'd15 || hi !== 32'd0 || pe !== 0) begin errors++; $display("FAIL mul_after_flush: got dc=%0d %h_%h pe=%0d want 33 0_15 0", dc, hi, lo, pe); end
    last_lo = lo; last_hi = hi;
  endtask

  task automatic test_flush_start_idle();
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.flush = 1'b1; bus.a = 32'd11; bus.b = 32'd13;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_start_stall: got %b want 0", bus.stall); end
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    checks++; if ({bus.stall, bus.busy, bus.done} !== 3'b000 || bus.result_lo !== last_lo || bus.result_hi !== last_hi) begin
      errors++; $display("FAIL flush_start_idle: stall=%b busy=%b done=%b res=%h_%h want 0 0 0 %h_%h",
                         bus.stall, bus.busy, bus.done, bus.result_hi, bus.result_lo, last_hi, last_lo);
    end
  endtask

  task automatic test_ignore_start();
    int dc, pe, lat; logic [WIDTH-1:0] lo, hi, elo, ehi, a_v, b_v; logic dbz, edbz;
    for (int i = 0; i < 2; i++) begin
      a_v = $urandom; b_v = $urandom | 32'h1;
      ref_op(1'(i), a_v, b_v, elo, ehi, edbz, lat);
      run_op(1'(i), a_v, b_v, -1, 1'b1, 2, dc, lo, hi, dbz, pe);
      checks++;
      if (dc !== lat || lo !== elo || hi !== ehi || dbz !== edbz || pe !== 0) begin
        errors++; $display("FAIL ignore_start op=%0d: got dc=%0d %h_%h dbz=%b pe=%0d want %0d %h_%h %b 0",
                           i, dc, hi, lo, dbz, pe, lat, ehi, elo, edbz);
      end
      last_lo = elo; last_hi = ehi;
    end
  endtask

  task automatic test_reset_mid_div();
    int dc, pe; logic [WIDTH-1:0] lo, hi; logic dbz;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      bus.start = (k == 0); bus.op = 1'b1; bus.a = 32'd1000000; bus.b = 32'd3; bus.flush = 1'b0;
      reset = (k == 20);
      #1;
      if (k == 21) begin
        checks++;
        if ({bus.stall, bus.busy, bus.done, bus.div_by_zero, bus.result_lo, bus.result_hi} !== '0) begin
          errors++; $display("FAIL reset_mid_div: stall=%b busy=%b done=%b dbz=%b lo=%h hi=%h want all 0",
                             bus.stall, bus.busy, bus.done, bus.div_by_zero, bus.result_lo, bus.result_hi);
        end
      end
    end
    last_lo = '0; last_hi = '0;
    run_op(1'b0, 32'd2, 32'd3, -1, 1'b0, 2, dc, lo, hi, dbz, pe);
    checks++; if (dc !== 33 || lo !== 32'd6 || hi !== 32'd0 || pe !== 0) begin errors++; $display("FAIL mul_after_reset: got dc=%0d %h_%h pe=%0d want 33 0_6 0", dc, hi, lo, pe); end
    last_lo = lo; last_hi = hi;
  endtask

  task automatic test_random();
    int dc, pe, lat; logic [WIDTH-1:0] lo, hi, elo, ehi, a_v, b_v; logic dbz, edbz, op_v;
    for (int i = 0; i < 24; i++) begin
      op_v = 1'($urandom_range(0, 1));
      a_v  = $urandom;
      case ($urandom_range(0, 5))
        0: b_v = '0;
        1: b_v = 32'($urandom_range(1, 15));
        default: b_v = $urandom;
      endcase
      ref_op(op_v, a_v, b_v, elo, ehi, edbz, lat);
      run_op(op_v, a_v, b_v, -1, 1'b0, 1 + (i % 2), dc, lo, hi, dbz, pe);
      checks++;
      if (dc !== lat || lo !== elo || hi !== ehi || dbz !== edbz || pe !== 0) begin
        errors++; $display("FAIL random_%0d op=%0d a=%h b=%h: got dc=%0d %h_%h dbz=%b pe=%0d want %0d %h_%h %b 0",
                           i, op_v, a_v, b_v, dc, hi, lo, dbz, pe, lat, ehi, elo, edbz);
      end
      last_lo = elo; last_hi = ehi;
    end
  endtask

  task automatic test_back_to_back();
    int dc, pe, lat; logic [WIDTH-1:0] lo, hi, elo, ehi, a_v, b_v; logic dbz, edbz, op_v;
    for (int i = 0; i < 4; i++) begin
      op_v = (i != 0);
      a_v  = $urandom;
      b_v  = (i == 2) ? '0 : $urandom;
      ref_op(op_v, a_v, b_v, elo, ehi, edbz, lat);
      run_op(op_v, a_v, b_v, -1, 1'b0, 1, dc, lo, hi, dbz, pe);
      checks++;
      if (dc !== lat || lo !== elo || hi !== ehi || dbz !== edbz || pe !== 0) begin
        errors++; $display("FAIL back_to_back_%0d: got dc=%0d %h_%h dbz=%b pe=%0d want %0d %h_%h %b 0",
                           i, dc, hi, lo, dbz, pe, lat, ehi, elo, edbz);
      end
      last_lo = elo; last_hi = ehi;
    end
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    checks++; if (bus.result_lo !== last_lo || bus.result_hi !== last_hi || bus.done !== 1'b0) begin
      errors++; $display("FAIL result_hold: got %h_%h done=%b want %h_%h 0", bus.result_hi, bus.result_lo, bus.done, last_hi, last_lo);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_flush();
    test_flush_start_idle();
    test_ignore_start();
    test_reset_mid_div();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
